// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer with ReLU: one signed MAC is time-shared
// across all neurons, and weights are streamed from an external ROM.
module fc_layer_seq #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int OUT   = 10,
    parameter int ACC_W = WIDTH*2 + $clog2(IN),
    parameter int AW    = $clog2(IN*OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic [AW-1:0]         w_addr,
    output logic                  w_en,
    input  logic [WIDTH-1:0]      w_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic [$clog2(OUT):0]  out_idx,
    output logic                  out_last,
    output logic                  busy
);
    localparam int IW = $clog2(IN);
    localparam int NW = $clog2(OUT) + 1;
    localparam int PW = 2*WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, EMIT} state_t;
    state_t state, state_nx;

    logic [IW-1:0]        i, i_d;
    logic [NW-1:0]        n;
    logic [ACC_W-1:0]     acc;
    logic                 mac_v;
    logic [WIDTH-1:0]     x_buf [IN];
    logic signed [PW-1:0] prod;
    logic                 i_last, n_last, beat, hs;

    assign i_last = (i == IW'(IN-1));
    assign n_last = (n == NW'(OUT-1));
    assign beat   = in_valid & in_ready;
    assign hs     = out_valid & out_ready;
    assign prod   = $signed(x_buf[i_d]) * $signed(w_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        w_en     = 1'b0;
        w_addr   = '0;
        busy     = 1'b0;
        case (state)
            IDLE: state_nx = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && i_last) state_nx = COMPUTE;
            end
            COMPUTE: begin
                busy   = 1'b1;
                w_en   = 1'b1;
                w_addr = AW'(n) * AW'(IN) + AW'(i);
                if (i_last) state_nx = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = EMIT;
            end
            EMIT: begin
                busy = 1'b1;
                if (hs) state_nx = n_last ? LOAD : COMPUTE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Weight data arrives one cycle after w_en, so the MAC runs on the delayed index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i         <= '0;
            i_d       <= '0;
            n         <= '0;
            acc       <= '0;
            mac_v     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            mac_v <= w_en;
            i_d   <= i;
            if (mac_v) acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (i_last) begin
                            i   <= '0;
                            n   <= '0;
                            acc <= '0;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end
                end
                COMPUTE: i <= i_last ? '0 : i + 1'b1;
                DRAIN:   out_valid <= 1'b1;
                EMIT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (!n_last) begin
                            n   <= n + 1'b1;
                            acc <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat) x_buf[i] <= in_data;
    end

    // ACC_W is wide enough for IN worst-case products, so ReLU is the only clamp.
    assign out_data = (out_valid && !acc[ACC_W-1]) ? acc : '0;
    assign out_idx  = out_valid ? n : '0;
    assign out_last = out_valid & n_last;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq with IN=4, OUT=2 and a registered weight ROM model.
module tb_fc_layer_seq;
    localparam int WIDTH = 8;
    localparam int IN    = 4;
    localparam int OUT   = 2;
    localparam int ACC_W = 18;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst_n, in_valid, in_ready, w_en, out_valid, out_ready, out_last, busy;
    logic [WIDTH-1:0]  in_data, w_data;
    logic [AW-1:0]     w_addr;
    logic [ACC_W-1:0]  out_data;
    logic [1:0]        out_idx;

    logic [7:0]  rom [8];
    logic [20:0] outq [$];
    int          hs_cyc [$];
    int          wq_addr [$];
    int          wq_cyc [$];
    int          cyc = 0;
    int          beat_cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_addr(w_addr), .w_en(w_en), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always @(posedge clk) begin
        if (w_en) w_data <= rom[w_addr];
    end

    always @(posedge clk) begin
        if (w_en) begin
            wq_addr.push_back(int'(w_addr));
            wq_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            outq.push_back({out_data, out_idx, out_last});
            hs_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) beat_cyc = cyc;
        cyc = cyc + 1;
    end

    task automatic clear_logs();
        outq.delete();
        hs_cyc.delete();
        wq_addr.delete();
        wq_cyc.delete();
    endtask

    task automatic set_rom(input logic [63:0] v);
        for (int k = 0; k < 8; k++) rom[k] = v[8*k +: 8];
    endtask

    task automatic send_vec(input logic [31:0] xv, input logic [15:0] gaps);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b0;
            repeat (int'(gaps[4*k +: 4])) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = xv[8*k +: 8];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_out(input int nouts, input bit noise, output int rdy_hits);
        int t;
        t = 0;
        rdy_hits = 0;
        out_ready = 1'b1;
        while (outq.size() < nouts && t < 300) begin
            if (noise) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            @(posedge clk); #1;
            t++;
            if (outq.size() < nouts && in_ready) rdy_hits++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, w_en, w_addr, out_valid, out_data, out_idx, out_last, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {in_ready, w_en, w_addr, out_valid, out_data, out_idx, out_last, busy});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_idle_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin failures++; $display("FAIL reset_load got=%b exp=10", {in_ready, busy}); end
    endtask

    task automatic test_basic();
        int rh, bad;
        clear_logs();
        set_rom(64'hFFFFFFFF_01010101);
        send_vec(32'h04030201, 16'h0000);
        run_out(2, 1'b0, rh);
        checks++;
        if (outq.size() !== 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", outq.size()); end
        if (outq.size() >= 2) begin
            checks++;
            if (outq[0] !== {18'd10, 2'd0, 1'b0}) begin failures++; $display("FAIL basic_n0 got=%0h exp=%0h", outq[0], {18'd10, 2'd0, 1'b0}); end
            checks++;
            if (outq[1] !== {18'd0, 2'd1, 1'b1}) begin failures++; $display("FAIL basic_n1 got=%0h exp=%0h", outq[1], {18'd0, 2'd1, 1'b1}); end
        end
        bad = 0;
        for (int k = 0; k < wq_addr.size(); k++) if (wq_addr[k] != k) bad++;
        checks++;
        if (wq_addr.size() !== 8 || bad != 0) begin failures++; $display("FAIL basic_waddr got=%0d/%0d exp=8/0", wq_addr.size(), bad); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
    endtask

    task automatic test_extreme();
        int rh;
        clear_logs();
        set_rom(64'h80808080_80808080);
        send_vec(32'h80808080, 16'h0000);
        run_out(2, 1'b0, rh);
        checks++;
        if (outq.size() !== 2) begin failures++; $display("FAIL extreme_count got=%0d exp=2", outq.size()); end
        if (outq.size() >= 2) begin
            checks++;
            if (outq[0] !== {18'd65536, 2'd0, 1'b0}) begin failures++; $display("FAIL extreme_n0 got=%0h exp=%0h", outq[0], {18'd65536, 2'd0, 1'b0}); end
            checks++;
            if (outq[1] !== {18'd65536, 2'd1, 1'b1}) begin failures++; $display("FAIL extreme_n1 got=%0h exp=%0h", outq[1], {18'd65536, 2'd1, 1'b1}); end
        end
    endtask

    task automatic test_backpressure();
        int t, bad, rh;
        clear_logs();
        set_rom(64'hFFFFFFFF_01010101);
        out_ready = 1'b0;
        send_vec(32'h04030201, 16'h0000);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout got=%b exp=1", out_valid); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if ({out_valid, out_data, out_idx, w_en} !== {1'b1, 18'd10, 2'd0, 1'b0}) bad++;
            if (k < 4) begin @(posedge clk); #1; end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_stable got=%0d bad cycles exp=0", bad); end
        checks++;
        if (wq_addr.size() !== 4) begin failures++; $display("FAIL bp_no_idx1 got=%0d reads exp=4", wq_addr.size()); end
        run_out(2, 1'b0, rh);
        checks++;
        if (outq.size() !== 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", outq.size()); end
        if (outq.size() >= 2 && wq_cyc.size() >= 5) begin
            checks++;
            if (outq[1] !== {18'd0, 2'd1, 1'b1}) begin failures++; $display("FAIL bp_n1 got=%0h exp=%0h", outq[1], {18'd0, 2'd1, 1'b1}); end
            checks++;
            if (wq_cyc[4] !== hs_cyc[0] + 1) begin failures++; $display("FAIL bp_idx1_start got=%0d exp=%0d", wq_cyc[4], hs_cyc[0] + 1); end
        end
    endtask

    task automatic test_gaps();
        int rh, bad;
        clear_logs();
        set_rom(64'hFFFFFFFF_01010101);
        send_vec(32'h04030201, 16'h1020);
        run_out(2, 1'b0, rh);
        checks++;
        if (outq.size() !== 2) begin failures++; $display("FAIL gaps_count got=%0d exp=2", outq.size()); end
        if (outq.size() >= 2) begin
            checks++;
            if (outq[0] !== {18'd10, 2'd0, 1'b0}) begin failures++; $display("FAIL gaps_n0 got=%0h exp=%0h", outq[0], {18'd10, 2'd0, 1'b0}); end
            checks++;
            if (outq[1] !== {18'd0, 2'd1, 1'b1}) begin failures++; $display("FAIL gaps_n1 got=%0h exp=%0h", outq[1], {18'd0, 2'd1, 1'b1}); end
        end
        bad = 0;
        for (int k = 0; k < wq_addr.size(); k++) if (wq_addr[k] != k) bad++;
        checks++;
        if (wq_addr.size() !== 8 || bad != 0) begin failures++; $display("FAIL gaps_waddr got=%0d/%0d exp=8/0", wq_addr.size(), bad); end
        if (wq_cyc.size() >= 1) begin
            checks++;
            if (wq_cyc[0] !== beat_cyc + 1) begin failures++; $display("FAIL gaps_first_wen got=%0d exp=%0d", wq_cyc[0], beat_cyc + 1); end
        end
    endtask

    task automatic test_reset_mid();
        int t, rh;
        clear_logs();
        set_rom(64'hFFFFFFFF_01010101);
        send_vec(32'h04030201, 16'h0000);
        out_ready = 1'b1;
        t = 0;
        while (!(w_en && w_addr >= 3'd5) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, w_en, w_addr, out_valid, out_data, out_idx, out_last, busy} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got=%0h exp=0",
                     {in_ready, w_en, w_addr, out_valid, out_data, out_idx, out_last, busy});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy} !== 2'b00) begin failures++; $display("FAIL midrst_idle got=%b exp=00", {in_ready, busy}); end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_load got=%b exp=1", in_ready); end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (outq.size() !== 1) begin failures++; $display("FAIL midrst_stale got=%0d outputs exp=1", outq.size()); end
        clear_logs();
        set_rom(64'h01010101_03000000);
        send_vec(32'h05000000, 16'h0000);
        run_out(2, 1'b0, rh);
        checks++;
        if (outq.size() !== 2) begin failures++; $display("FAIL midrst_count got=%0d exp=2", outq.size()); end
        if (outq.size() >= 2) begin
            checks++;
            if (outq[0] !== {18'd15, 2'd0, 1'b0}) begin failures++; $display("FAIL midrst_n0 got=%0h exp=%0h", outq[0], {18'd15, 2'd0, 1'b0}); end
            checks++;
            if (outq[1] !== {18'd5, 2'd1, 1'b1}) begin failures++; $display("FAIL midrst_n1 got=%0h exp=%0h", outq[1], {18'd5, 2'd1, 1'b1}); end
        end
    endtask

    task automatic test_in_ignored();
        int rh;
        clear_logs();
        set_rom(64'hFFFFFFFF_01010101);
        send_vec(32'h04030201, 16'h0000);
        run_out(2, 1'b1, rh);
        checks++;
        if (rh != 0) begin failures++; $display("FAIL ignore_ready got=%0d cycles exp=0", rh); end
        checks++;
        if (outq.size() !== 2) begin failures++; $display("FAIL ignore_count got=%0d exp=2", outq.size()); end
        if (outq.size() >= 2) begin
            checks++;
            if (outq[0] !== {18'd10, 2'd0, 1'b0}) begin failures++; $display("FAIL ignore_n0 got=%0h exp=%0h", outq[0], {18'd10, 2'd0, 1'b0}); end
            checks++;
            if (outq[1] !== {18'd0, 2'd1, 1'b1}) begin failures++; $display("FAIL ignore_n1 got=%0h exp=%0h", outq[1], {18'd0, 2'd1, 1'b1}); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_in_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
